ice40_ebr_ram: RTL and testbench



---
 rtl/ice40_ebr_ram_pkg.sv | 18 +
 rtl/ice40_ebr_ram_if.sv | 23 ++
 rtl/ice40_ebr_ram.sv | 61 ++++++
 tb/tb_ice40_ebr_ram.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/ice40_ebr_ram_pkg.sv
// Geometry encoding shared by the EBR model and its wrappers: mode selects
// depth/width so that depth * width is always 4096 bits.
package ice40_ebr_ram_pkg;

    localparam int MODE_256X16 = 0;
    localparam int MODE_512X8  = 1;
    localparam int MODE_1024X4 = 2;
    localparam int MODE_2048X2 = 3;

    function automatic int aw_of(input int mode);
        return 8 + mode;
    endfunction

    function automatic int dw_of(input int mode);
        return 16 >> mode;
    endfunction

endpackage

// File: rtl/ice40_ebr_ram_if.sv
// Write/read port bundle of one EBR; widths follow the chosen geometry.
interface ice40_ebr_ram_if #(
    parameter int AW = 8,
    parameter int DW = 16
);
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [DW-1:0] wr_mask;
    logic          wr_ena;
    logic [AW-1:0] rd_addr;
    logic          rd_ena;
    logic [DW-1:0] rd_data;

    modport master (
        output wr_addr, wr_data, wr_mask, wr_ena, rd_addr, rd_ena,
        input  rd_data
    );

    modport slave (
        input  wr_addr, wr_data, wr_mask, wr_ena, rd_addr, rd_ena,
        output rd_data
    );
endinterface

// File: rtl/ice40_ebr_ram.sv
// One iCE40 4 Kbit EBR as a simple dual-port RAM: masked write port on either
// clock edge, registered read port on the rising edge.
module ice40_ebr_ram
    import ice40_ebr_ram_pkg::*;
#(
    parameter int READ_MODE       = 0,
    parameter int WRITE_MODE      = 0,
    parameter int MASK_WORKAROUND = 0,
    parameter int NEG_WR_CLK      = 0
) (
    input  logic            clk,
    input  logic            rst,
    ice40_ebr_ram_if.slave  bus
);

    localparam int AW    = aw_of(READ_MODE);
    localparam int DW    = dw_of(READ_MODE);
    localparam int DEPTH = 1 << AW;
    // Silicon only honours the bit mask in 256x16; other modes write whole words
    localparam bit HONOUR_MASK = (MASK_WORKAROUND != 0) || (READ_MODE == MODE_256X16);

    if (READ_MODE != WRITE_MODE) begin : g_mode_mismatch
        $fatal(1, "ice40_ebr_ram: READ_MODE and WRITE_MODE must be equal");
    end
    if (READ_MODE < MODE_256X16 || READ_MODE > MODE_2048X2) begin : g_mode_range
        $fatal(1, "ice40_ebr_ram: READ_MODE must be 0..3");
    end

    logic [DW-1:0] mem [DEPTH] = '{default: '0};
    logic [DW-1:0] eff_mask;
    logic [DW-1:0] rd_data_p1;

    assign eff_mask = HONOUR_MASK ? bus.wr_mask : '0;

    // Write stage: edge chosen at elaboration
    if (NEG_WR_CLK != 0) begin : g_wr_neg
        always_ff @(negedge clk) begin
            if (bus.wr_ena && !rst) begin
                mem[bus.wr_addr] <= (mem[bus.wr_addr] & eff_mask) | (bus.wr_data & ~eff_mask);
            end
        end
    end else begin : g_wr_pos
        always_ff @(posedge clk) begin
            if (bus.wr_ena && !rst) begin
                mem[bus.wr_addr] <= (mem[bus.wr_addr] & eff_mask) | (bus.wr_data & ~eff_mask);
            end
        end
    end

    // Read stage: one-cycle registered output, reset wins over enable
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_p1 <= '0;
        end else if (bus.rd_ena) begin
            rd_data_p1 <= mem[bus.rd_addr];
        end
    end

    assign bus.rd_data = rd_data_p1;

endmodule

// File: tb/tb_ice40_ebr_ram.sv
// Self-checking bench: five EBR configurations driven side by side against
// plain array models of the memory contents.
module tb_ice40_ebr_ram;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    ice40_ebr_ram_if #(.AW(8),  .DW(16)) b0 ();
    ice40_ebr_ram_if #(.AW(8),  .DW(16)) b1 ();
    ice40_ebr_ram_if #(.AW(10), .DW(4))  b2 ();
    ice40_ebr_ram_if #(.AW(10), .DW(4))  b3 ();
    ice40_ebr_ram_if #(.AW(11), .DW(2))  b4 ();

    ice40_ebr_ram #(.READ_MODE(0), .WRITE_MODE(0), .MASK_WORKAROUND(0), .NEG_WR_CLK(0))
        u0 (.clk(clk), .rst(rst), .bus(b0.slave));
    ice40_ebr_ram #(.READ_MODE(0), .WRITE_MODE(0), .MASK_WORKAROUND(0), .NEG_WR_CLK(1))
        u1 (.clk(clk), .rst(rst), .bus(b1.slave));
    ice40_ebr_ram #(.READ_MODE(2), .WRITE_MODE(2), .MASK_WORKAROUND(0), .NEG_WR_CLK(0))
        u2 (.clk(clk), .rst(rst), .bus(b2.slave));
    ice40_ebr_ram #(.READ_MODE(2), .WRITE_MODE(2), .MASK_WORKAROUND(1), .NEG_WR_CLK(0))
        u3 (.clk(clk), .rst(rst), .bus(b3.slave));
    ice40_ebr_ram #(.READ_MODE(3), .WRITE_MODE(3), .MASK_WORKAROUND(0), .NEG_WR_CLK(0))
        u4 (.clk(clk), .rst(rst), .bus(b4.slave));

    logic [15:0] m0 [256];
    logic [15:0] m1 [256];
    logic [3:0]  m2 [1024];
    logic [3:0]  m3 [1024];
    logic [1:0]  m4 [2048];

    // Spec rule: mask bit 1 keeps the old bit; ignored mask writes every bit
    function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] d,
                                          input logic [15:0] mask, input bit honour);
        return honour ? ((old & mask) | (d & ~mask)) : d;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        b0.wr_ena = 0; b0.rd_ena = 0; b0.wr_addr = '0; b0.wr_data = '0; b0.wr_mask = '0; b0.rd_addr = '0;
        b1.wr_ena = 0; b1.rd_ena = 0; b1.wr_addr = '0; b1.wr_data = '0; b1.wr_mask = '0; b1.rd_addr = '0;
        b2.wr_ena = 0; b2.rd_ena = 0; b2.wr_addr = '0; b2.wr_data = '0; b2.wr_mask = '0; b2.rd_addr = '0;
        b3.wr_ena = 0; b3.rd_ena = 0; b3.wr_addr = '0; b3.wr_data = '0; b3.wr_mask = '0; b3.rd_addr = '0;
        b4.wr_ena = 0; b4.rd_ena = 0; b4.wr_addr = '0; b4.wr_data = '0; b4.wr_mask = '0; b4.rd_addr = '0;
    endtask

    task automatic test_reset();
        idle_all();
        rst = 1;
        tick();
        tick();
        checks++;
        if (b0.rd_data !== 16'h0) begin errors++; $display("FAIL reset_u0 got %h want 0000", b0.rd_data); end
        checks++;
        if (b2.rd_data !== 4'h0) begin errors++; $display("FAIL reset_u2 got %h want 0", b2.rd_data); end
        checks++;
        if (b4.rd_data !== 2'h0) begin errors++; $display("FAIL reset_u4 got %h want 0", b4.rd_data); end
        rst = 0;
        tick();
    endtask

    task automatic test_mode0_mask();
        b0.wr_ena = 1; b0.wr_addr = 8'h12; b0.wr_data = 16'hA5A5; b0.wr_mask = 16'h0000;
        tick();
        m0[8'h12] = merge(m0[8'h12], 16'hA5A5, 16'h0000, 1);
        b0.wr_ena = 0; b0.rd_ena = 1; b0.rd_addr = 8'h12;
        tick();
        b0.rd_ena = 0;
        checks++;
        if (b0.rd_data !== 16'hA5A5) begin errors++; $display("FAIL full_write got %h want a5a5", b0.rd_data); end
        b0.wr_ena = 1; b0.wr_addr = 8'h12; b0.wr_data = 16'h5A5A; b0.wr_mask = 16'hFF00;
        tick();
        m0[8'h12] = merge(m0[8'h12], 16'h5A5A, 16'hFF00, 1);
        b0.wr_ena = 0; b0.rd_ena = 1;
        tick();
        b0.rd_ena = 0;
        checks++;
        if (b0.rd_data !== 16'hA55A) begin errors++; $display("FAIL masked_write got %h want a55a", b0.rd_data); end
        checks++;
        if (b0.rd_data !== m0[8'h12]) begin errors++; $display("FAIL masked_model got %h want %h", b0.rd_data, m0[8'h12]); end
    endtask

    task automatic test_mask_workaround();
        b2.wr_ena = 1; b2.wr_addr = 10'h3FF; b2.wr_data = 4'hF; b2.wr_mask = 4'hF;
        b3.wr_ena = 1; b3.wr_addr = 10'h3FF; b3.wr_data = 4'hF; b3.wr_mask = 4'hF;
        tick();
        m2[10'h3FF] = 4'(merge(16'(m2[10'h3FF]), 16'hF, 16'hF, 0));
        m3[10'h3FF] = 4'(merge(16'(m3[10'h3FF]), 16'hF, 16'hF, 1));
        b2.wr_ena = 0; b3.wr_ena = 0;
        b2.rd_ena = 1; b2.rd_addr = 10'h3FF; b3.rd_ena = 1; b3.rd_addr = 10'h3FF;
        tick();
        b2.rd_ena = 0; b3.rd_ena = 0;
        checks++;
        if (b2.rd_data !== 4'hF) begin errors++; $display("FAIL mask_ignored got %h want f", b2.rd_data); end
        checks++;
        if (b3.rd_data !== 4'h0) begin errors++; $display("FAIL mask_honoured got %h want 0", b3.rd_data); end
    endtask

    task automatic test_hold_and_reset();
        b0.rd_ena = 1; b0.rd_addr = 8'h12;
        tick();
        b0.rd_ena = 0; b0.rd_addr = 8'h00;
        tick();
        checks++;
        if (b0.rd_data !== 16'hA55A) begin errors++; $display("FAIL hold got %h want a55a", b0.rd_data); end
        // Reset beats a pending read and blocks a write presented alongside it
        rst = 1; b0.rd_ena = 1; b0.rd_addr = 8'h12;
        b0.wr_ena = 1; b0.wr_addr = 8'h20; b0.wr_data = 16'hFFFF; b0.wr_mask = 16'h0000;
        tick();
        rst = 0; b0.wr_ena = 0; b0.rd_ena = 0;
        checks++;
        if (b0.rd_data !== 16'h0) begin errors++; $display("FAIL rst_clears got %h want 0000", b0.rd_data); end
        b0.rd_ena = 1; b0.rd_addr = 8'h12;
        tick();
        checks++;
        if (b0.rd_data !== m0[8'h12]) begin errors++; $display("FAIL rst_keeps_mem got %h want %h", b0.rd_data, m0[8'h12]); end
        b0.rd_addr = 8'h20;
        tick();
        b0.rd_ena = 0;
        checks++;
        if (b0.rd_data !== m0[8'h20]) begin errors++; $display("FAIL rst_blocks_write got %h want %h", b0.rd_data, m0[8'h20]); end
    endtask

    task automatic test_read_during_write();
        b0.wr_ena = 1; b0.wr_addr = 8'h40; b0.wr_data = 16'h1234; b0.wr_mask = 16'h0;
        b1.wr_ena = 1; b1.wr_addr = 8'h40; b1.wr_data = 16'h1234; b1.wr_mask = 16'h0;
        b0.rd_ena = 1; b0.rd_addr = 8'h40; b1.rd_ena = 1; b1.rd_addr = 8'h40;
        tick();
        checks++;
        if (b0.rd_data !== m0[8'h40]) begin errors++; $display("FAIL rdw_old got %h want %h", b0.rd_data, m0[8'h40]); end
        m0[8'h40] = 16'h1234;
        m1[8'h40] = 16'h1234;
        checks++;
        if (b1.rd_data !== 16'h1234) begin errors++; $display("FAIL rdw_new got %h want 1234", b1.rd_data); end
        b0.wr_ena = 0; b1.wr_ena = 0;
        tick();
        b0.rd_ena = 0; b1.rd_ena = 0;
        checks++;
        if (b0.rd_data !== 16'h1234) begin errors++; $display("FAIL rdw_next got %h want 1234", b0.rd_data); end
    endtask

    task automatic test_mode3_edges();
        logic [10:0] addrs [4];
        addrs[0] = 11'd0; addrs[1] = 11'd1; addrs[2] = 11'd2046; addrs[3] = 11'd2047;
        for (int i = 0; i < 4; i++) begin
            b4.wr_ena = 1; b4.wr_addr = addrs[i]; b4.wr_data = 2'(i); b4.wr_mask = 2'b11;
            tick();
            m4[addrs[i]] = 2'(i);
        end
        for (int i = 0; i < 8; i++) begin
            b4.wr_ena = 0; b4.wr_addr = addrs[i % 4]; b4.wr_data = 2'($urandom);
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            b4.rd_ena = 1; b4.rd_addr = addrs[i];
            tick();
            checks++;
            if (b4.rd_data !== 2'(i)) begin
                errors++; $display("FAIL mode3_edge addr %0d got %0d want %0d", addrs[i], b4.rd_data, i);
            end
        end
        b4.rd_ena = 0;
    endtask

    task automatic test_random();
        logic [15:0] exp0, exp1;
        logic [1:0]  exp4;
        logic [7:0]  wa, ra;
        logic [10:0] wa4, ra4;
        logic [15:0] d, mk;
        bit          we, re, we4, re4;
        exp0 = b0.rd_data; exp1 = b1.rd_data; exp4 = b4.rd_data;
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 31) == 0);
            we = $urandom_range(0, 1); re = $urandom_range(0, 1);
            wa = 8'($urandom_range(0, 15)); ra = 8'($urandom_range(0, 15));
            d = 16'($urandom); mk = ($urandom_range(0, 2) == 0) ? 16'h0 : 16'($urandom);
            we4 = $urandom_range(0, 1); re4 = $urandom_range(0, 1);
            wa4 = 11'($urandom_range(0, 7) + ($urandom_range(0, 1) ? 2040 : 0));
            ra4 = 11'($urandom_range(0, 7) + ($urandom_range(0, 1) ? 2040 : 0));
            b0.wr_ena = we; b0.wr_addr = wa; b0.wr_data = d; b0.wr_mask = mk; b0.rd_ena = re; b0.rd_addr = ra;
            b1.wr_ena = we; b1.wr_addr = wa; b1.wr_data = d; b1.wr_mask = mk; b1.rd_ena = re; b1.rd_addr = ra;
            b4.wr_ena = we4; b4.wr_addr = wa4; b4.wr_data = d[1:0]; b4.wr_mask = mk[1:0];
            b4.rd_ena = re4; b4.rd_addr = ra4;
            // Rising-edge write: read sees contents before this cycle's write
            if (rst) exp0 = 16'h0; else if (re) exp0 = m0[ra];
            if (rst) exp4 = 2'h0; else if (re4) exp4 = m4[ra4];
            if (!rst && we) m0[wa] = merge(m0[wa], d, mk, 1);
            if (!rst && we4) m4[wa4] = d[1:0];
            // Falling-edge write lands before the read edge of the same cycle
            if (!rst && we) m1[wa] = merge(m1[wa], d, mk, 1);
            if (rst) exp1 = 16'h0; else if (re) exp1 = m1[ra];
            tick();
            checks++;
            if (b0.rd_data !== exp0) begin errors++; $display("FAIL rand_u0 cyc %0d got %h want %h", n, b0.rd_data, exp0); end
            checks++;
            if (b1.rd_data !== exp1) begin errors++; $display("FAIL rand_u1 cyc %0d got %h want %h", n, b1.rd_data, exp1); end
            checks++;
            if (b4.rd_data !== exp4) begin errors++; $display("FAIL rand_u4 cyc %0d got %h want %h", n, b4.rd_data, exp4); end
        end
        rst = 0;
        idle_all();
        tick();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin m0[i] = '0; m1[i] = '0; end
        for (int i = 0; i < 1024; i++) begin m2[i] = '0; m3[i] = '0; end
        for (int i = 0; i < 2048; i++) m4[i] = '0;
        rst = 1;
        test_reset();
        test_mode0_mask();
        test_mask_workaround();
        test_hold_and_reset();
        test_read_during_write();
        test_mode3_edges();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
